// File: rtl/tone_gen_if.sv
// Key-strobe and audio-output bundle for tone_gen.
// The player/sequencer side uses master; tone_gen uses slave.
interface tone_gen_if #(
    parameter int DIV_W = 6
);
    logic [3:0]       key;
    logic [1:0]       octave;
    logic             key_valid;
    logic             stop;
    logic             tone;
    logic             playing;
    logic [DIV_W-1:0] note_div;
    logic             key_err;

    modport master (
        output key, octave, key_valid, stop,
        input  tone, playing, note_div, key_err
    );

    modport slave (
        input  key, octave, key_valid, stop,
        output tone, playing, note_div, key_err
    );
endinterface

// File: rtl/tone_gen.sv
// Square-wave note generator: a prescaler scaled by octave feeds a half-period
// counter that toggles tone every note_div ticks. All outputs come from flops.
module tone_gen #(
    parameter int DIV_W    = 6,
    parameter int PRESCALE = 256
) (
    input  logic        clk,
    input  logic        rst,
    tone_gen_if.slave   bus
);
    localparam int PS_W = $clog2(PRESCALE);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t           state, state_nxt;
    logic             tone_q, tone_nxt;
    logic             err_q, err_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [DIV_W-1:0] hcnt_q, hcnt_nxt;
    logic [PS_W-1:0]  ps_q, ps_nxt;
    logic [1:0]       oct_q, oct_nxt;
    logic [PS_W-1:0]  ps_term;
    logic             key_bad, key_ok, tick;

    function automatic logic [DIV_W-1:0] key_div(input logic [3:0] k);
        logic [5:0] d;
        case (k)
            4'd0:    d = 6'd38;
            4'd1:    d = 6'd36;
            4'd2:    d = 6'd34;
            4'd3:    d = 6'd32;
            4'd4:    d = 6'd30;
            4'd5:    d = 6'd29;
            4'd6:    d = 6'd27;
            4'd7:    d = 6'd26;
            4'd8:    d = 6'd24;
            4'd9:    d = 6'd23;
            4'd10:   d = 6'd21;
            4'd11:   d = 6'd20;
            default: d = 6'd0;
        endcase
        return DIV_W'(d);
    endfunction

    assign key_bad = bus.key_valid && (bus.key >= 4'd12);
    assign key_ok  = bus.key_valid && !key_bad && !bus.stop;
    // Higher octaves shorten the tick interval by powers of two.
    assign ps_term = PS_W'((PRESCALE >> oct_q) - 1);
    assign tick    = (ps_q == ps_term);

    always_comb begin
        state_nxt = state;
        tone_nxt  = tone_q;
        div_nxt   = div_q;
        oct_nxt   = oct_q;
        ps_nxt    = '0;
        hcnt_nxt  = '0;
        err_nxt   = key_bad;
        if (bus.stop || key_bad) begin
            state_nxt = IDLE;
            tone_nxt  = 1'b0;
            div_nxt   = '0;
        end else if (key_ok) begin
            // Accept or retrigger: phase restarts high with both counters at 0.
            state_nxt = PLAY;
            tone_nxt  = 1'b1;
            div_nxt   = key_div(bus.key);
            oct_nxt   = bus.octave;
        end else if (state == PLAY) begin
            ps_nxt   = tick ? '0 : ps_q + 1'b1;
            hcnt_nxt = hcnt_q;
            if (tick) begin
                if (hcnt_q == div_q - 1'b1) begin
                    hcnt_nxt = '0;
                    tone_nxt = !tone_q;
                end else begin
                    hcnt_nxt = hcnt_q + 1'b1;
                end
            end
        end else begin
            tone_nxt = 1'b0;
            div_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tone_q <= 1'b0;
            err_q  <= 1'b0;
            div_q  <= '0;
            hcnt_q <= '0;
            ps_q   <= '0;
            oct_q  <= '0;
        end else begin
            state  <= state_nxt;
            tone_q <= tone_nxt;
            err_q  <= err_nxt;
            div_q  <= div_nxt;
            hcnt_q <= hcnt_nxt;
            ps_q   <= ps_nxt;
            oct_q  <= oct_nxt;
        end
    end

    assign bus.tone     = tone_q;
    assign bus.playing  = (state == PLAY);
    assign bus.note_div = div_q;
    assign bus.key_err  = err_q;
endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen at PRESCALE=8: directed note scenarios plus random strobes,
// every cycle compared against a time-based model of the expected waveform.
module tb_tone_gen;
    localparam int DIV_W    = 6;
    localparam int PRESCALE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_gen_if #(.DIV_W(DIV_W)) bus ();

    tone_gen #(.DIV_W(DIV_W), .PRESCALE(PRESCALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tbl [12] = '{38, 36, 34, 32, 30, 29, 27, 26, 24, 23, 21, 20};

    int n_chk  = 0;
    int n_pass = 0;

    // Model: note start edge and half-period length determine tone directly.
    longint cyc   = 0;
    longint m_t0  = 0;
    bit     m_play = 0;
    int     m_div  = 0;
    int     m_oct  = 0;
    bit     m_err  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic bit exp_tone();
        longint half;
        if (!m_play) return 1'b0;
        half = longint'(m_div) * (PRESCALE >> m_oct);
        return ((cyc - m_t0) / half) % 2 == 0;
    endfunction

    task automatic step(input logic r, input logic kv, input logic [3:0] k,
                        input logic [1:0] o, input logic s);
        rst           = r;
        bus.key_valid = kv;
        bus.key       = k;
        bus.octave    = o;
        bus.stop      = s;
        @(posedge clk);
        cyc++;
        m_err = !r && kv && (k >= 12);
        if (r || s || (kv && k >= 12)) begin
            m_play = 0;
            m_div  = 0;
        end else if (kv) begin
            m_play = 1;
            m_div  = tbl[k];
            m_oct  = o;
            m_t0   = cyc;
        end
        #1;
        chk("tone",     32'(bus.tone),     32'(exp_tone()));
        chk("playing",  32'(bus.playing),  32'(m_play));
        chk("note_div", 32'(bus.note_div), 32'(m_div));
        chk("key_err",  32'(bus.key_err),  32'(m_err));
    endtask

    // Idle cycle with garbage on key/octave, which must be ignored.
    task automatic idle();
        step(1'b0, 1'b0, 4'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic wait_toggle(output int n);
        logic prev;
        prev = bus.tone;
        n = 0;
        do begin
            idle();
            n++;
        end while (bus.tone == prev && n < 2000);
    endtask

    int n;

    initial begin
        bus.key = '0; bus.octave = '0; bus.key_valid = 1'b0; bus.stop = 1'b0;

        step(1'b1, 1'b1, 4'd9, 2'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
        repeat (3) idle();

        // Key A, octave 0: half period 23*8
        step(1'b0, 1'b1, 4'd9, 2'd0, 1'b0);
        wait_toggle(n); chk("a_half_hi", n, 184);
        wait_toggle(n); chk("a_half_lo", n, 184);

        // Key C, octave 3: one tick per clock
        step(1'b0, 1'b1, 4'd0, 2'd3, 1'b0);
        wait_toggle(n); chk("c3_half", n, 38);
        wait_toggle(n); chk("c3_half2", n, 38);

        // Invalid key while playing
        step(1'b0, 1'b1, 4'd13, 2'd1, 1'b0);
        chk("bad_err", 32'(bus.key_err), 1);
        idle();
        chk("bad_err_clr", 32'(bus.key_err), 0);

        // Stop beats a simultaneous valid key
        step(1'b0, 1'b1, 4'd9, 2'd0, 1'b0);
        repeat (10) idle();
        step(1'b0, 1'b1, 4'd4, 2'd0, 1'b1);
        chk("stop_play", 32'(bus.playing), 0);
        repeat (5) idle();

        // Stop with invalid key still flags the key
        step(1'b0, 1'b1, 4'd15, 2'd0, 1'b1);
        chk("stop_bad_err", 32'(bus.key_err), 1);

        // Retrigger 50 clocks into the low half
        step(1'b0, 1'b1, 4'd9, 2'd0, 1'b0);
        wait_toggle(n); chk("rt_fall", n, 184);
        repeat (50) idle();
        step(1'b0, 1'b1, 4'd4, 2'd0, 1'b0);
        chk("rt_tone", 32'(bus.tone), 1);
        wait_toggle(n); chk("rt_half", n, 240);

        // Same-key retrigger restarts the phase
        repeat (100) idle();
        step(1'b0, 1'b1, 4'd4, 2'd0, 1'b0);
        wait_toggle(n); chk("same_rt_half", n, 240);

        // Reset mid-play with a key strobe in the same cycle
        repeat (30) idle();
        step(1'b1, 1'b1, 4'd5, 2'd0, 1'b0);
        chk("rst_tone", 32'(bus.tone), 0);
        repeat (20) idle();
        chk("rst_hold", 32'(bus.playing), 0);

        // Random traffic
        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 199) == 0),
                 4'($urandom),
                 2'($urandom),
                 ($urandom_range(0, 499) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
